// File: rtl/instr_sequencer.sv
// instr_sequencer: in-order instruction fetch/issue front end.
// Fetches from ins_addr and issues one instruction per cycle to decode.
// A write-back scoreboard stalls any instruction whose source register
// is still in flight. JMP is resolved here; JMF is issued and the
// sequencer then waits for EX to resolve it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | fetch, hazard check, issue or stall each non-hold cycle
// WAIT_BR | JMF issued, PC parked on the JMF, waiting for br_valid
// HALT    | HALT fetched; nothing issues until reset
module instr_sequencer #(
    parameter int AW     = 8,
    parameter int WB_LAT = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [AW-1:0] ins_addr,
    input  logic [31:0]   ins_di,
    input  logic          hold,
    input  logic          br_valid,
    input  logic          br_taken,
    output logic          iss_valid,
    output logic [7:0]    iss_op,
    output logic [7:0]    iss_a,
    output logic [7:0]    iss_b,
    output logic [7:0]    iss_c,
    output logic          halted
);

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_ADD   = 8'h01;
    localparam logic [7:0] OP_MUL   = 8'h02;
    localparam logic [7:0] OP_SOU   = 8'h03;
    localparam logic [7:0] OP_DIV   = 8'h04;
    localparam logic [7:0] OP_COP   = 8'h05;
    localparam logic [7:0] OP_AFC   = 8'h06;
    localparam logic [7:0] OP_LOAD  = 8'h07;
    localparam logic [7:0] OP_STORE = 8'h08;
    localparam logic [7:0] OP_JMP   = 8'h0E;
    localparam logic [7:0] OP_JMF   = 8'h0F;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_BR = 2'd1,
        HALT    = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] tgt_q;
    logic          br_pend;
    logic          br_pend_taken;
    logic          iss_valid_q;

    logic [WB_LAT-1:0] sb_valid;
    logic [3:0]        sb_dest [WB_LAT];

    logic [7:0]    op;
    logic [7:0]    fa;
    logic [7:0]    fb;
    logic [7:0]    fc;
    logic          is_writer;
    logic          rd_b;
    logic          rd_c;
    logic          op_known;
    logic          hazard;
    logic          issue_now;
    logic          head_valid;
    logic          br_fire;
    logic          br_dir;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] jmp_tgt;

    assign op      = ins_di[31:24];
    assign fa      = ins_di[23:16];
    assign fb      = ins_di[15:8];
    assign fc      = ins_di[7:0];
    assign pc_inc  = ins_addr + AW'(1);
    assign jmp_tgt = AW'(fa);

    // Classify the fetched opcode: does it write A, and which fields does it read
    always_comb begin
        is_writer = 1'b0;
        rd_b      = 1'b0;
        rd_c      = 1'b0;
        op_known  = 1'b1;
        case (op)
            OP_ADD, OP_MUL, OP_SOU, OP_DIV: begin
                is_writer = 1'b1;
                rd_b      = 1'b1;
                rd_c      = 1'b1;
            end
            OP_COP: begin
                is_writer = 1'b1;
                rd_b      = 1'b1;
            end
            OP_AFC, OP_LOAD: is_writer = 1'b1;
            OP_STORE, OP_JMF: rd_b = 1'b1;
            OP_NOP, OP_JMP, OP_HALT: ;
            default: op_known = 1'b0;
        endcase
    end

    // Compare sources against in-flight destinations; the tail entry writes
    // back on this same edge, so it no longer blocks the reader
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < WB_LAT - 1; i++) begin
            if (sb_valid[i] &&
                ((rd_b && (sb_dest[i] == fb[3:0])) ||
                 (rd_c && (sb_dest[i] == fc[3:0]))))
                hazard = 1'b1;
        end
    end

    assign issue_now  = (state == RUN) && !hazard && (op != OP_JMP) && (op != OP_HALT);
    assign head_valid = issue_now && is_writer;
    assign br_fire    = br_valid || br_pend;
    assign br_dir     = br_valid ? br_taken : br_pend_taken;
    assign iss_valid  = iss_valid_q && !hold;

    // Scoreboard shift: one slot per non-hold cycle, bubbles enter as invalid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_valid <= '0;
            for (int i = 0; i < WB_LAT; i++) sb_dest[i] <= '0;
        end else if (!hold) begin
            sb_valid[0] <= head_valid;
            sb_dest[0]  <= fa[3:0];
            for (int i = 1; i < WB_LAT; i++) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_dest[i]  <= sb_dest[i-1];
            end
        end
    end

    // Fetch/issue FSM: PC, branch tracking, issue registers and halt flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            ins_addr      <= '0;
            tgt_q         <= '0;
            br_pend       <= 1'b0;
            br_pend_taken <= 1'b0;
            iss_valid_q   <= 1'b0;
            iss_op        <= '0;
            iss_a         <= '0;
            iss_b         <= '0;
            iss_c         <= '0;
            halted        <= 1'b0;
        end else if (hold) begin
            // Everything is frozen, but a resolution arriving now must not be lost
            if ((state == WAIT_BR) && br_valid) begin
                br_pend       <= 1'b1;
                br_pend_taken <= br_taken;
            end
        end else begin
            iss_valid_q <= 1'b0;
            case (state)
                RUN: begin
                    if (issue_now) begin
                        iss_valid_q <= 1'b1;
                        iss_op      <= op_known ? op : OP_NOP;
                        iss_a       <= fa;
                        iss_b       <= fb;
                        iss_c       <= fc;
                    end
                    if (!hazard) begin
                        case (op)
                            OP_JMP: ins_addr <= jmp_tgt;
                            OP_JMF: begin
                                tgt_q <= jmp_tgt;
                                state <= WAIT_BR;
                            end
                            OP_HALT: begin
                                state  <= HALT;
                                halted <= 1'b1;
                            end
                            default: ins_addr <= pc_inc;
                        endcase
                    end
                end
                WAIT_BR: begin
                    if (br_fire) begin
                        ins_addr <= br_dir ? tgt_q : pc_inc;
                        state    <= RUN;
                        br_pend  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer (AW=8, WB_LAT=3).
module tb_instr_sequencer;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hold;
    logic          br_valid;
    logic          br_taken;
    logic [AW-1:0] ins_addr;
    logic [31:0]   ins_di;
    logic          iss_valid;
    logic [7:0]    iss_op;
    logic [7:0]    iss_a;
    logic [7:0]    iss_b;
    logic [7:0]    iss_c;
    logic          halted;

    logic [31:0] imem [256];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    assign ins_di = imem[ins_addr];

    instr_sequencer #(.AW(AW), .WB_LAT(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ins_addr (ins_addr),
        .ins_di   (ins_di),
        .hold     (hold),
        .br_valid (br_valid),
        .br_taken (br_taken),
        .iss_valid(iss_valid),
        .iss_op   (iss_op),
        .iss_a    (iss_a),
        .iss_b    (iss_b),
        .iss_c    (iss_c),
        .halted   (halted)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    endtask

    // Hold reset for two edges, then release just after an edge
    task automatic start();
        rst_n    = 1'b0;
        hold     = 1'b0;
        br_valid = 1'b0;
        br_taken = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_mem();
        imem[0] = 32'h0F30_0000;
        rst_n = 1'b0; hold = 1'b0; br_valid = 1'b0; br_taken = 1'b0;
        step();
        step();
        tests_run++;
        if (ins_addr !== 8'h00) begin tests_failed++; $display("FAIL rst_addr: got %h exp 00", ins_addr); end
        tests_run++;
        if (iss_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b exp 0", iss_valid); end
        tests_run++;
        if ({iss_op, iss_a, iss_b, iss_c} !== 32'h0) begin
            tests_failed++; $display("FAIL rst_fields: got %h exp 00000000", {iss_op, iss_a, iss_b, iss_c});
        end
        tests_run++;
        if (halted !== 1'b0) begin tests_failed++; $display("FAIL rst_halted: got %b exp 0", halted); end
        // Reset while waiting on a branch must drop the pending JMF entirely
        rst_n = 1'b1;
        step();
        tests_run++;
        if (iss_valid !== 1'b1 || iss_op !== 8'h0F || ins_addr !== 8'h00) begin
            tests_failed++; $display("FAIL rst_jmf_issue: got v=%b op=%h addr=%h exp v=1 op=0f addr=00", iss_valid, iss_op, ins_addr);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (iss_valid !== 1'b0 || ins_addr !== 8'h00) begin
            tests_failed++; $display("FAIL rst_async: got v=%b addr=%h exp v=0 addr=00", iss_valid, ins_addr);
        end
        imem[0] = 32'h0;
        step();
        rst_n    = 1'b1;
        br_valid = 1'b1;
        br_taken = 1'b1;
        step();
        br_valid = 1'b0;
        tests_run++;
        if (ins_addr !== 8'h01 || iss_valid !== 1'b1) begin
            tests_failed++; $display("FAIL rst_midbr: got addr=%h v=%b exp addr=01 v=1", ins_addr, iss_valid);
        end
    endtask

    task automatic test_back_to_back();
        bit [7:0] ea [4];
        bit [7:0] eo [4];
        bit [7:0] ef [4];
        clear_mem();
        imem[0] = 32'h0601_0005;
        imem[1] = 32'h0602_0007;
        imem[2] = 32'h0103_0405;
        imem[3] = 32'h4211_2233;
        ea = '{8'h01, 8'h02, 8'h03, 8'h04};
        eo = '{8'h06, 8'h06, 8'h01, 8'h00};
        ef = '{8'h01, 8'h02, 8'h03, 8'h11};
        start();
        tests_run++;
        if (ins_addr !== 8'h00 || iss_valid !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_first_fetch: got addr=%h v=%b exp addr=00 v=0", ins_addr, iss_valid);
        end
        for (int e = 0; e < 4; e++) begin
            step();
            tests_run++;
            if (iss_valid !== 1'b1 || ins_addr !== ea[e] || iss_op !== eo[e] || iss_a !== ef[e]) begin
                tests_failed++;
                $display("FAIL b2b_edge%0d: got v=%b addr=%h op=%h a=%h exp v=1 addr=%h op=%h a=%h",
                         e + 1, iss_valid, ins_addr, iss_op, iss_a, ea[e], eo[e], ef[e]);
            end
        end
    endtask

    task automatic test_dependency();
        bit       ev [11];
        bit [7:0] ea [11];
        bit [7:0] eo [11];
        clear_mem();
        imem[0] = 32'h0601_0005;
        imem[1] = 32'h0102_0101;
        imem[2] = 32'h0603_0001;
        imem[3] = 32'h0304_0003;
        imem[4] = 32'h0800_0400;
        ev = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        ea = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h03, 8'h03, 8'h03, 8'h04, 8'h04, 8'h04, 8'h05};
        eo = '{8'h06, 8'h00, 8'h00, 8'h01, 8'h06, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h08};
        start();
        for (int e = 0; e < 11; e++) begin
            step();
            tests_run++;
            if (iss_valid !== ev[e] || ins_addr !== ea[e] || (ev[e] && iss_op !== eo[e])) begin
                tests_failed++;
                $display("FAIL dep_edge%0d: got v=%b addr=%h op=%h exp v=%b addr=%h op=%h",
                         e + 1, iss_valid, ins_addr, iss_op, ev[e], ea[e], eo[e]);
            end
        end
    endtask

    task automatic test_jmp();
        bit       ev [6];
        bit [7:0] ea [6];
        bit [7:0] eo [6];
        clear_mem();
        imem[4]  = 32'h0E10_0000;
        imem[16] = 32'h0603_0009;
        ev = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        ea = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h11};
        eo = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h06};
        start();
        for (int e = 0; e < 6; e++) begin
            step();
            tests_run++;
            if (iss_valid !== ev[e] || ins_addr !== ea[e] || (ev[e] && iss_op !== eo[e])) begin
                tests_failed++;
                $display("FAIL jmp_edge%0d: got v=%b addr=%h op=%h exp v=%b addr=%h op=%h",
                         e + 1, iss_valid, ins_addr, iss_op, ev[e], ea[e], eo[e]);
            end
        end
    endtask

    task automatic test_branch();
        // Taken branch; a stray br_valid in RUN beforehand must be ignored
        clear_mem();
        imem[6]     = 32'h0F20_0700;
        imem[8'h20] = 32'h0604_0001;
        start();
        for (int e = 1; e <= 6; e++) begin
            step();
            br_valid = (e == 3);
            br_taken = (e == 3);
            if (e == 4) begin
                tests_run++;
                if (ins_addr !== 8'h04) begin tests_failed++; $display("FAIL br_ignore_run: got addr=%h exp 04", ins_addr); end
            end
        end
        step();
        tests_run++;
        if (iss_valid !== 1'b1 || iss_op !== 8'h0F || iss_a !== 8'h20 || iss_b !== 8'h07 || ins_addr !== 8'h06) begin
            tests_failed++; $display("FAIL br_jmf_issue: got v=%b op=%h a=%h b=%h addr=%h exp v=1 op=0f a=20 b=07 addr=06",
                                     iss_valid, iss_op, iss_a, iss_b, ins_addr);
        end
        step();
        tests_run++;
        if (iss_valid !== 1'b0 || ins_addr !== 8'h06) begin
            tests_failed++; $display("FAIL br_wait: got v=%b addr=%h exp v=0 addr=06", iss_valid, ins_addr);
        end
        br_valid = 1'b1; br_taken = 1'b1;
        step();
        br_valid = 1'b0; br_taken = 1'b0;
        tests_run++;
        if (iss_valid !== 1'b0 || ins_addr !== 8'h20) begin
            tests_failed++; $display("FAIL br_taken: got v=%b addr=%h exp v=0 addr=20", iss_valid, ins_addr);
        end
        step();
        tests_run++;
        if (iss_valid !== 1'b1 || iss_op !== 8'h06 || ins_addr !== 8'h21) begin
            tests_failed++; $display("FAIL br_after_taken: got v=%b op=%h addr=%h exp v=1 op=06 addr=21", iss_valid, iss_op, ins_addr);
        end

        // Not taken, with the JMF first stalled behind AFC R7
        clear_mem();
        imem[5] = 32'h0607_0001;
        imem[6] = 32'h0F20_0700;
        start();
        for (int e = 1; e <= 5; e++) step();
        step();
        tests_run++;
        if (iss_valid !== 1'b1 || iss_op !== 8'h06 || ins_addr !== 8'h06) begin
            tests_failed++; $display("FAIL brn_producer: got v=%b op=%h addr=%h exp v=1 op=06 addr=06", iss_valid, iss_op, ins_addr);
        end
        for (int e = 7; e <= 8; e++) begin
            step();
            tests_run++;
            if (iss_valid !== 1'b0 || ins_addr !== 8'h06) begin
                tests_failed++; $display("FAIL brn_stall_edge%0d: got v=%b addr=%h exp v=0 addr=06", e, iss_valid, ins_addr);
            end
        end
        step();
        tests_run++;
        if (iss_valid !== 1'b1 || iss_op !== 8'h0F || ins_addr !== 8'h06) begin
            tests_failed++; $display("FAIL brn_jmf_issue: got v=%b op=%h addr=%h exp v=1 op=0f addr=06", iss_valid, iss_op, ins_addr);
        end
        step();
        br_valid = 1'b1; br_taken = 1'b0;
        step();
        br_valid = 1'b0;
        tests_run++;
        if (iss_valid !== 1'b0 || ins_addr !== 8'h07) begin
            tests_failed++; $display("FAIL brn_not_taken: got v=%b addr=%h exp v=0 addr=07", iss_valid, ins_addr);
        end
        step();
        tests_run++;
        if (iss_valid !== 1'b1 || ins_addr !== 8'h08) begin
            tests_failed++; $display("FAIL brn_resume: got v=%b addr=%h exp v=1 addr=08", iss_valid, ins_addr);
        end

        // Branch resolution arriving under hold is remembered
        clear_mem();
        imem[6]     = 32'h0F20_0700;
        imem[8'h20] = 32'h0604_0001;
        start();
        for (int e = 1; e <= 7; e++) step();
        hold = 1'b1; br_valid = 1'b1; br_taken = 1'b1;
        #1;
        tests_run++;
        if (iss_valid !== 1'b0) begin tests_failed++; $display("FAIL brh_mask: got v=%b exp v=0", iss_valid); end
        step();
        br_valid = 1'b0; br_taken = 1'b0;
        step();
        tests_run++;
        if (ins_addr !== 8'h06) begin tests_failed++; $display("FAIL brh_frozen: got addr=%h exp 06", ins_addr); end
        hold = 1'b0;
        step();
        tests_run++;
        if (iss_valid !== 1'b0 || ins_addr !== 8'h20) begin
            tests_failed++; $display("FAIL brh_latched: got v=%b addr=%h exp v=0 addr=20", iss_valid, ins_addr);
        end
        step();
        tests_run++;
        if (iss_valid !== 1'b1 || iss_op !== 8'h06 || ins_addr !== 8'h21) begin
            tests_failed++; $display("FAIL brh_resume: got v=%b op=%h addr=%h exp v=1 op=06 addr=21", iss_valid, iss_op, ins_addr);
        end
    endtask

    task automatic test_halt();
        clear_mem();
        imem[9]  = 32'hFF00_0000;
        imem[10] = 32'h0601_0001;
        start();
        for (int e = 1; e <= 9; e++) step();
        tests_run++;
        if (ins_addr !== 8'h09 || halted !== 1'b0) begin
            tests_failed++; $display("FAIL halt_pre: got addr=%h halted=%b exp addr=09 halted=0", ins_addr, halted);
        end
        for (int e = 10; e <= 15; e++) begin
            br_valid = (e == 12);
            br_taken = (e == 12);
            step();
            tests_run++;
            if (iss_valid !== 1'b0 || ins_addr !== 8'h09 || halted !== 1'b1) begin
                tests_failed++; $display("FAIL halt_edge%0d: got v=%b addr=%h halted=%b exp v=0 addr=09 halted=1",
                                         e, iss_valid, ins_addr, halted);
            end
        end
        br_valid = 1'b0; br_taken = 1'b0;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (iss_valid !== 1'b0 || ins_addr !== 8'h00 || halted !== 1'b0) begin
            tests_failed++; $display("FAIL halt_reset: got v=%b addr=%h halted=%b exp v=0 addr=00 halted=0", iss_valid, ins_addr, halted);
        end
        step();
        rst_n = 1'b1;
        step();
        tests_run++;
        if (iss_valid !== 1'b1 || ins_addr !== 8'h01 || halted !== 1'b0) begin
            tests_failed++; $display("FAIL halt_restart: got v=%b addr=%h halted=%b exp v=1 addr=01 halted=0", iss_valid, ins_addr, halted);
        end
    endtask

    task automatic test_hold_wrap();
        clear_mem();
        imem[0]     = 32'h0EFE_0000;
        imem[8'hFE] = 32'h0601_0005;
        imem[8'hFF] = 32'h0102_0101;
        start();
        step();
        tests_run++;
        if (iss_valid !== 1'b0 || ins_addr !== 8'hFE) begin
            tests_failed++; $display("FAIL hw_jmp: got v=%b addr=%h exp v=0 addr=fe", iss_valid, ins_addr);
        end
        step();
        tests_run++;
        if (iss_valid !== 1'b1 || iss_op !== 8'h06 || ins_addr !== 8'hFF) begin
            tests_failed++; $display("FAIL hw_producer: got v=%b op=%h addr=%h exp v=1 op=06 addr=ff", iss_valid, iss_op, ins_addr);
        end
        step();
        tests_run++;
        if (iss_valid !== 1'b0 || ins_addr !== 8'hFF) begin
            tests_failed++; $display("FAIL hw_bubble1: got v=%b addr=%h exp v=0 addr=ff", iss_valid, ins_addr);
        end
        hold = 1'b1;
        for (int e = 4; e <= 6; e++) begin
            step();
            tests_run++;
            if (iss_valid !== 1'b0 || ins_addr !== 8'hFF) begin
                tests_failed++; $display("FAIL hw_hold_edge%0d: got v=%b addr=%h exp v=0 addr=ff", e, iss_valid, ins_addr);
            end
        end
        hold = 1'b0;
        step();
        tests_run++;
        if (iss_valid !== 1'b0 || ins_addr !== 8'hFF) begin
            tests_failed++; $display("FAIL hw_bubble2: got v=%b addr=%h exp v=0 addr=ff", iss_valid, ins_addr);
        end
        step();
        tests_run++;
        if (iss_valid !== 1'b1 || iss_op !== 8'h01 || iss_a !== 8'h02 || ins_addr !== 8'h00) begin
            tests_failed++; $display("FAIL hw_dependent: got v=%b op=%h a=%h addr=%h exp v=1 op=01 a=02 addr=00",
                                     iss_valid, iss_op, iss_a, ins_addr);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        hold     = 1'b0;
        br_valid = 1'b0;
        br_taken = 1'b0;
        clear_mem();
        test_reset();
        test_back_to_back();
        test_dependency();
        test_jmp();
        test_branch();
        test_halt();
        test_hold_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
